// File: rtl/alu_exec_unit.sv
// EX-stage ALU: alu_op/funct decode, registered single-cycle results, iterative MULT/DIV into HI/LO.
// Mul/div hardware is present only when ALU_EXEC_MULDIV_EN is defined.
module alu_exec_unit #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       func_code,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    // state | meaning
    // IDLE  | accepting ops; single-cycle ops complete on the accept edge
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_t;

    state_t           state, state_nx;
    logic             accept;
    logic [WIDTH-1:0] res_c;
    logic             ill_c;
    logic             start_md;

    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready;

`ifdef ALU_EXEC_MULDIV_EN
    logic             start_div, signed_op;
    logic [WIDTH-1:0] hi, lo, acc, wrk, mag_b, op_a;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [SHW-1:0]   cnt;
    logic             neg_q, neg_r, b_zero, last, md_done;
    logic [WIDTH:0]   mul_sum, r_sh;
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0] div_sub, rem_nx, quo_nx, q_fin, r_fin, md_lo;
    logic             div_ge;

    assign a_mag   = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (signed_op && b[WIDTH-1]) ? -b : b;
    assign last    = (cnt == '0);
    assign md_done = last && (state != IDLE);
`endif

    always_comb begin
        res_c    = '0;
        ill_c    = 1'b0;
        start_md = 1'b0;
`ifdef ALU_EXEC_MULDIV_EN
        start_div = 1'b0;
        signed_op = 1'b0;
`endif
        case (alu_op)
            2'b00: res_c = a + b;
            2'b01: res_c = a - b;
            2'b11: res_c = a | b;
            default: begin
                case (func_code)
                    6'b100000, 6'b100001: res_c = a + b;
                    6'b100010, 6'b100011: res_c = a - b;
                    6'b100100: res_c = a & b;
                    6'b100101: res_c = a | b;
                    6'b100110: res_c = a ^ b;
                    6'b100111: res_c = ~(a | b);
                    6'b101010: res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
                    6'b101011: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
                    6'b000000: res_c = b << shamt;
                    6'b000010: res_c = b >> shamt;
                    6'b000011: res_c = $unsigned($signed(b) >>> shamt);
                    6'b000100: res_c = b << a[SHW-1:0];
                    6'b000110: res_c = b >> a[SHW-1:0];
`ifdef ALU_EXEC_MULDIV_EN
                    6'b010000: res_c = hi;
                    6'b010010: res_c = lo;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
                        start_md  = 1'b1;
                        start_div = func_code[1];
                        signed_op = ~func_code[0];
                    end
`else
                    6'b010000, 6'b010010: res_c = '0;
`endif
                    default: ill_c = 1'b1;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
`ifdef ALU_EXEC_MULDIV_EN
        case (state)
            IDLE:     if (accept && start_md) state_nx = start_div ? DIV : MUL;
            MUL, DIV: if (last) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
`else
        state_nx = IDLE;
`endif
    end

`ifdef ALU_EXEC_MULDIV_EN
    // {acc, wrk} is the product register for MUL and {remainder, dividend/quotient} for DIV
    always_comb begin
        mul_sum  = {1'b0, acc} + (wrk[0] ? {1'b0, mag_b} : {(WIDTH+1){1'b0}});
        prod_raw = {mul_sum, wrk[WIDTH-1:1]};
        prod     = neg_q ? -prod_raw : prod_raw;
        r_sh     = {acc, wrk[WIDTH-1]};
        div_ge   = (r_sh >= {1'b0, mag_b});
        div_sub  = r_sh[WIDTH-1:0] - mag_b;
        rem_nx   = div_ge ? div_sub : r_sh[WIDTH-1:0];
        quo_nx   = {wrk[WIDTH-2:0], div_ge};
        q_fin    = b_zero ? {WIDTH{1'b1}} : (neg_q ? -quo_nx : quo_nx);
        r_fin    = b_zero ? op_a : (neg_r ? -rem_nx : rem_nx);
        md_lo    = (state == MUL) ? prod[WIDTH-1:0] : q_fin;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            wrk    <= '0;
            mag_b  <= '0;
            op_a   <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else if (accept && start_md) begin
            acc    <= '0;
            wrk    <= a_mag;
            mag_b  <= b_mag;
            op_a   <= a;
            neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= signed_op && a[WIDTH-1];
            b_zero <= (b == '0);
            cnt    <= SHW'(WIDTH-1);
        end else if (state == MUL) begin
            {acc, wrk} <= prod_raw;
            cnt        <= cnt - 1'b1;
            if (last) {hi, lo} <= prod;
        end else if (state == DIV) begin
            cnt <= cnt - 1'b1;
            if (!b_zero) begin
                acc <= rem_nx;
                wrk <= quo_nx;
            end
            if (last) begin
                hi <= r_fin;
                lo <= q_fin;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !start_md) begin
                out_valid <= 1'b1;
                result    <= res_c;
                zero      <= (res_c == '0);
                illegal   <= ill_c;
            end
`ifdef ALU_EXEC_MULDIV_EN
            else if (md_done) begin
                out_valid <= 1'b1;
                result    <= md_lo;
                zero      <= (md_lo == '0);
                illegal   <= 1'b0;
            end
`endif
        end
    end

endmodule
